// File: rtl/divisor_seq_pkg.sv
// Shared types and helpers for the sequential signed divider.
// Optional overflow flag port V is enabled by defining DIVISOR_OVF_EN.
package divisor_pkg;

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  localparam int ABS_W = 32;

  // One extra bit so the most negative input has an exact magnitude.
  function automatic logic [ABS_W:0] abs_ext(input logic signed [ABS_W-1:0] a);
    logic [ABS_W:0] ax;
    ax = {a[ABS_W-1], a};
    return a[ABS_W-1] ? -ax : ax;
  endfunction

endpackage

// File: rtl/divisor_seq_if.sv
// Start/busy/done handshake and result bus between the divider and its controller.
// V is present only when DIVISOR_OVF_EN is defined.
interface divisor_seq_if #(parameter int NUM_BITS = 8);
  logic                start;
  logic [NUM_BITS-1:0] A, B;
  logic                busy, done;
  logic [NUM_BITS-1:0] Q, R;
  logic                Z, N, P, div_zero;
`ifdef DIVISOR_OVF_EN
  logic                V;
  modport master (output start, A, B, input busy, done, Q, R, Z, N, P, div_zero, V);
  modport slave  (input start, A, B, output busy, done, Q, R, Z, N, P, div_zero, V);
`else
  modport master (output start, A, B, input busy, done, Q, R, Z, N, P, div_zero);
  modport slave  (input start, A, B, output busy, done, Q, R, Z, N, P, div_zero);
`endif
endinterface

// File: rtl/divisor_seq_passo.sv
// One restoring shift-subtract step on unsigned magnitudes; iterated by the divider FSM.
module divisor_passo #(
  parameter int NUM_BITS = 8
) (
  input  logic [NUM_BITS:0]   rem_i,
  input  logic [NUM_BITS-1:0] quo_i,
  input  logic [NUM_BITS:0]   div_i,
  output logic [NUM_BITS:0]   rem_o,
  output logic [NUM_BITS-1:0] quo_o
);
  logic [NUM_BITS+1:0] sh, dv;
  logic                ge;

  assign sh    = {rem_i, quo_i[NUM_BITS-1]};
  assign dv    = {1'b0, div_i};
  assign ge    = sh >= dv;
  assign rem_o = (NUM_BITS+1)'(ge ? sh - dv : sh);
  assign quo_o = {quo_i[NUM_BITS-2:0], ge};
endmodule

// File: rtl/divisor_seq.sv
// Sequential signed divider, truncating toward zero, one quotient bit per clock.
// Define DIVISOR_OVF_EN to add the V (overflow) output.
module divisor_seq
  import divisor_pkg::*;
#(
  parameter int NUM_BITS = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  divisor_seq_if.slave  bus
);
  localparam int CW = $clog2(NUM_BITS);

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NUM_BITS:0]   rem_q, rem_d, bmag_q, bmag_d;
  logic [NUM_BITS-1:0] quo_q, quo_d;
  logic                sgnq_q, sgnq_d, sgnr_q, sgnr_d, dz_q, dz_d;

  logic [NUM_BITS-1:0] q_q, r_q;
  logic                z_q, n_q, p_q, dzo_q;

  logic signed [ABS_W-1:0] aext, bext;
  logic [NUM_BITS-1:0]     amag;
  logic [NUM_BITS:0]       bmag;
  logic [NUM_BITS:0]       step_rem;
  logic [NUM_BITS-1:0]     step_quo;
  logic [NUM_BITS-1:0]     q_res, r_mag, r_res;

  assign aext = {{(ABS_W-NUM_BITS){bus.A[NUM_BITS-1]}}, bus.A};
  assign bext = {{(ABS_W-NUM_BITS){bus.B[NUM_BITS-1]}}, bus.B};
  // |A| <= 2^(NUM_BITS-1) always fits NUM_BITS unsigned bits.
  assign amag = NUM_BITS'(abs_ext(aext));
  assign bmag = (NUM_BITS+1)'(abs_ext(bext));

  divisor_passo #(.NUM_BITS(NUM_BITS)) u_passo (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (bmag_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    bmag_d  = bmag_q;
    sgnq_d  = sgnq_q;
    sgnr_d  = sgnr_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: if (bus.start) begin
        sgnq_d  = bus.A[NUM_BITS-1] ^ bus.B[NUM_BITS-1];
        sgnr_d  = bus.A[NUM_BITS-1];
        quo_d   = amag;
        rem_d   = '0;
        bmag_d  = bmag;
        cnt_d   = CW'(NUM_BITS-1);
        dz_d    = (bus.B == '0);
        state_d = (bus.B == '0) ? FIX : ITER;
      end
      ITER: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = FIX;
      end
      FIX:     state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Divide-by-zero keeps |A| in quo so the remainder reproduces A.
  assign q_res = dz_q ? '1 : (sgnq_q ? -quo_q : quo_q);
  assign r_mag = dz_q ? quo_q : rem_q[NUM_BITS-1:0];
  assign r_res = sgnr_q ? -r_mag : r_mag;

`ifdef DIVISOR_OVF_EN
  logic v_q;
  // Only -2^(N-1) / -1 yields a positive magnitude with the top bit set.
  wire  v_res = !dz_q && !sgnq_q && quo_q[NUM_BITS-1];
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      bmag_q  <= '0;
      sgnq_q  <= 1'b0;
      sgnr_q  <= 1'b0;
      dz_q    <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      p_q     <= 1'b0;
      dzo_q   <= 1'b0;
`ifdef DIVISOR_OVF_EN
      v_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      bmag_q  <= bmag_d;
      sgnq_q  <= sgnq_d;
      sgnr_q  <= sgnr_d;
      dz_q    <= dz_d;
      if (state_q == FIX) begin
        q_q   <= q_res;
        r_q   <= r_res;
        z_q   <= (q_res == '0);
        n_q   <= q_res[NUM_BITS-1];
        p_q   <= ~q_res[0];
        dzo_q <= dz_q;
`ifdef DIVISOR_OVF_EN
        v_q   <= v_res;
`endif
      end
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == DONE);
  assign bus.Q        = q_q;
  assign bus.R        = r_q;
  assign bus.Z        = z_q;
  assign bus.N        = n_q;
  assign bus.P        = p_q;
  assign bus.div_zero = dzo_q;
`ifdef DIVISOR_OVF_EN
  assign bus.V        = v_q;
`endif
endmodule

// File: tb/tb_divisor_seq.sv
// Scoreboard bench for divisor_seq: driver issues divides, monitor checks results and latency.
module tb_divisor_seq;
  localparam int NB = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  divisor_seq_if #(.NUM_BITS(NB)) bus();
  divisor_seq #(.NUM_BITS(NB)) dut (.clock(clk), .reset_n(rst_n), .bus(bus.slave));

  typedef struct {
    int             a, b;
    logic [NB-1:0]  q, r;
    logic           z, n, p, dz, v;
    int             due;
  } exp_t;

  exp_t sb[$];
  exp_t e_m;
  int   cyc = 0;
  int   tests = 0, fails = 0;
  int   busy_run = 0;
  logic rst_chk = 1'b1;
  logic end_req = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer division; Q/R wrap to NB bits, done edge from start edge.
  function automatic exp_t model(input logic [NB-1:0] a, input logic [NB-1:0] b, input int start_edge);
    exp_t e;
    int ia, ib, iq, ir;
    ia = int'($signed(a));
    ib = int'($signed(b));
    if (ib == 0) begin iq = -1; ir = ia; end
    else begin iq = ia / ib; ir = ia % ib; end
    e.a   = ia;
    e.b   = ib;
    e.q   = NB'(iq);
    e.r   = NB'(ir);
    e.z   = (iq == 0);
    e.n   = ($signed(e.q) < 0);
    e.p   = (iq % 2 == 0);
    e.dz  = (ib == 0);
    e.v   = (iq > 2**(NB-1) - 1);
    e.due = start_edge + ((ib == 0) ? 1 : NB + 1);
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: the only process that compares and updates the counts.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_chk) begin
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_Q", int'(bus.Q), 0);
        chk("rst_R", int'(bus.R), 0);
        chk("rst_ZNP", int'({bus.Z, bus.N, bus.P}), 0);
        chk("rst_div_zero", int'(bus.div_zero), 0);
`ifdef DIVISOR_OVF_EN
        chk("rst_V", int'(bus.V), 0);
`endif
      end else if (rst_n && bus.done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          e_m = sb.pop_front();
          chk($sformatf("latency %0d/%0d", e_m.a, e_m.b), cyc, e_m.due);
          chk($sformatf("busy@done %0d/%0d", e_m.a, e_m.b), int'(bus.busy), 1);
          chk($sformatf("Q %0d/%0d", e_m.a, e_m.b), int'($signed(bus.Q)), int'($signed(e_m.q)));
          chk($sformatf("R %0d/%0d", e_m.a, e_m.b), int'($signed(bus.R)), int'($signed(e_m.r)));
          chk($sformatf("Z %0d/%0d", e_m.a, e_m.b), int'(bus.Z), int'(e_m.z));
          chk($sformatf("N %0d/%0d", e_m.a, e_m.b), int'(bus.N), int'(e_m.n));
          chk($sformatf("P %0d/%0d", e_m.a, e_m.b), int'(bus.P), int'(e_m.p));
          chk($sformatf("div_zero %0d/%0d", e_m.a, e_m.b), int'(bus.div_zero), int'(e_m.dz));
`ifdef DIVISOR_OVF_EN
          chk($sformatf("V %0d/%0d", e_m.a, e_m.b), int'(bus.V), int'(e_m.v));
`endif
        end
      end
      busy_run = bus.busy ? busy_run + 1 : 0;
      if (busy_run > NB + 4) begin
        chk("busy_timeout", busy_run, NB + 4);
        busy_run = 0;
      end
      if (end_req) begin
        chk("drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (bus.busy && n < 100) begin @(negedge clk); n++; end
  endtask

  // Issue one divide; poke re-pulses start while busy, which must be ignored.
  task automatic issue(input logic [NB-1:0] a, input logic [NB-1:0] b, input bit poke);
    wait_idle();
    bus.start = 1'b1; bus.A = a; bus.B = b;
    @(posedge clk); #1;
    sb.push_back(model(a, b, cyc));
    bus.start = 1'b0; bus.A = NB'($urandom); bus.B = NB'($urandom);
    if (poke) begin
      repeat (3) @(negedge clk);
      bus.start = 1'b1; bus.A = NB'($urandom); bus.B = NB'($urandom);
      @(negedge clk);
      bus.start = 1'b0;
    end
  endtask

  task automatic abort_mid_op(input logic [NB-1:0] a, input logic [NB-1:0] b);
    wait_idle();
    bus.start = 1'b1; bus.A = a; bus.B = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n   = 1'b0;
    rst_chk = 1'b1;
    @(negedge clk); #1;
    rst_chk = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    @(negedge clk); #1;
    rst_chk = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    issue(8'd100, 8'd7, 1'b0);
    issue(-8'sd100, 8'd7, 1'b0);
    issue(8'd100, -8'sd7, 1'b0);
    issue(8'd5, 8'd0, 1'b0);
    issue(8'h80, 8'hFF, 1'b0);
    issue(8'd3, 8'd5, 1'b0);
    issue(8'h80, 8'd0, 1'b0);
    issue(8'd127, 8'h80, 1'b0);
    issue(8'd100, 8'd7, 1'b1);
    abort_mid_op(8'd77, 8'd3);
    issue(-8'sd9, 8'd2, 1'b0);

    for (int i = 0; i < 150; i++) begin
      logic [NB-1:0] a, b;
      int sel;
      a   = NB'($urandom);
      b   = NB'($urandom);
      sel = int'($urandom_range(0, 9));
      if (sel == 0) b = '0;
      else if (sel == 1) b = '1;
      else if (sel == 2) a = 8'h80;
      issue(a, b, (i % 17 == 5) && (b != '0));
    end

    wait_idle();
    repeat (3) @(negedge clk);
    end_req = 1'b1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
